single_file_stimulus: RTL and testbench

SINGLE_FILE_STIMULUS -- requirements
Module: single_file_stimulus

---
 rtl/single_file_stimulus_pkg.sv | 36 +++
 rtl/file_line_parser.sv | 105 ++++++++++
 rtl/single_file_stimulus.sv | 163 ++++++++++++++++
 tb/tb_single_file_stimulus.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/single_file_stimulus_pkg.sv
// Shared types for the file-driven stimulus source: FSM states, the parameter
// bundle and a character-to-digit helper used by the line parser.
package single_file_stimulus_pkg;

    localparam int unsigned MaxLineLen = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_FETCH,
        S_DRIVE,
        S_DONE
    } state_e;

    typedef struct packed {
        int unsigned num_of_columns;
        int unsigned num_of_lines;
        int unsigned base;
        int unsigned lines_to_skip;
        int unsigned verbose;
        int unsigned carriage_return;
    } file_src_param_s;

    // Digit value of an ASCII character, all-ones when it is not a hex digit.
    function automatic logic [31:0] char_digit(input logic [7:0] ch);
        if (ch >= "0" && ch <= "9") begin
            return 32'(ch - "0");
        end else if (ch >= "a" && ch <= "f") begin
            return 32'(ch - "a") + 32'd10;
        end else if (ch >= "A" && ch <= "F") begin
            return 32'(ch - "A") + 32'd10;
        end
        return 32'hFFFF_FFFF;
    endfunction

endpackage

// File: rtl/file_line_parser.sv
// Parses the line starting at cursor_i out of the file image into integer fields.
// Blank lines are stepped over; lines longer than MaxLineLen bytes are truncated.
module file_line_parser
    import single_file_stimulus_pkg::*;
#(
    parameter int unsigned           NUM_OF_COLUMNS  = 2,
    parameter int unsigned           FILE_LEN        = 1,
    parameter logic [8*FILE_LEN-1:0] FILE_IMAGE      = '0,
    parameter int unsigned           BASE            = 10,
    parameter bit                    CARRIAGE_RETURN = 1'b0
) (
    input  logic [31:0]                     cursor_i,
    output logic [NUM_OF_COLUMNS-1:0][31:0] fields_o,
    output logic [31:0]                     count_o,
    output logic                            eof_o,
    output logic [31:0]                     next_o
);

    localparam logic [31:0] Radix = 32'(BASE);
    localparam logic [31:0] Len   = 32'(FILE_LEN);

    logic [31:0] pos;
    logic [31:0] acc;
    logic [31:0] dval;
    logic [7:0]  ch;
    logic        at_end, is_nl, is_ws, is_dig, is_neg;
    logic        started, ended, in_tok, tok_dig, neg, stopped;

    always_comb begin
        fields_o = '0;
        count_o  = '0;
        eof_o    = 1'b0;
        next_o   = cursor_i + 32'(MaxLineLen);
        pos      = cursor_i;
        acc      = '0;
        dval     = '0;
        ch       = '0;
        at_end   = 1'b0;
        is_nl    = 1'b0;
        is_ws    = 1'b0;
        is_dig   = 1'b0;
        is_neg   = 1'b0;
        started  = 1'b0;
        ended    = 1'b0;
        in_tok   = 1'b0;
        tok_dig  = 1'b0;
        neg      = 1'b0;
        stopped  = 1'b0;
        for (int j = 0; j < MaxLineLen; j++) begin
            if (!ended) begin
                pos    = cursor_i + 32'(j);
                at_end = (pos >= Len);
                // First character of the image sits in the most significant byte.
                ch     = at_end ? 8'h0A : 8'(FILE_IMAGE >> (8 * (Len - 32'd1 - pos)));
                is_nl  = at_end || (ch == 8'h0A);
                // NUL counts as whitespace so front padding of the image is harmless.
                is_ws  = (ch == 8'h20) || (ch == 8'h09) || (ch == 8'h00) ||
                         (CARRIAGE_RETURN && (ch == 8'h0D));
                dval   = char_digit(ch);
                is_dig = (dval < Radix);
                is_neg = (ch == "-") && (Radix == 32'd10);
                if (in_tok && !is_dig && !stopped) begin
                    if (tok_dig) begin
                        for (int k = 0; k < NUM_OF_COLUMNS; k++) begin
                            if (count_o == 32'(k)) fields_o[k] = neg ? -acc : acc;
                        end
                        count_o = count_o + 32'd1;
                    end else begin
                        stopped = 1'b1;
                    end
                    in_tok = 1'b0;
                end
                if (is_nl) begin
                    if (started || at_end) begin
                        ended  = 1'b1;
                        eof_o  = !started;
                        next_o = at_end ? Len : pos + 32'd1;
                    end
                end else if (!is_ws) begin
                    started = 1'b1;
                    if (!stopped) begin
                        if (is_dig) begin
                            if (!in_tok) begin
                                neg = 1'b0;
                                acc = dval;
                            end else begin
                                acc = acc * Radix + dval;
                            end
                            in_tok  = 1'b1;
                            tok_dig = 1'b1;
                        end else if (is_neg && !in_tok) begin
                            in_tok  = 1'b1;
                            tok_dig = 1'b0;
                            neg     = 1'b1;
                            acc     = '0;
                        end else begin
                            stopped = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/single_file_stimulus.sv
// Drives integer lines of a text stimulus image out through a valid/ready port.
// The file contents are supplied as the FILE_NAME byte image; an all-NUL image means no file.
module single_file_stimulus
    import single_file_stimulus_pkg::*;
#(
    parameter int unsigned           NUM_OF_COLUMNS  = 2,
    parameter int unsigned           FILE_LEN        = 1,
    parameter logic [8*FILE_LEN-1:0] FILE_NAME       = '0,
    parameter int unsigned           NUM_OF_LINES    = 0,
    parameter int unsigned           BASE            = 10,
    parameter int unsigned           LINES_TO_SKIP   = 0,
    parameter int unsigned           VERBOSE         = 0,
    parameter int unsigned           CARRIAGE_RETURN = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable_in,
    input  logic                            ready_in,
    output logic [NUM_OF_COLUMNS-1:0][31:0] data_out,
    output logic                            valid_out,
    output logic [31:0]                     line_count,
    output logic                            error_out,
    output logic                            all_done
);

    localparam file_src_param_s Cfg = '{
        num_of_columns:  NUM_OF_COLUMNS,
        num_of_lines:    NUM_OF_LINES,
        base:            BASE,
        lines_to_skip:   LINES_TO_SKIP,
        verbose:         VERBOSE,
        carriage_return: CARRIAGE_RETURN
    };
    localparam bit OpenFail = (FILE_NAME == '0);

    state_e                           state_q, state_d;
    logic [31:0]                      cursor_q, cursor_d;
    logic [31:0]                      skip_q, skip_d;
    logic [NUM_OF_COLUMNS-1:0][31:0]  data_q, data_d;
    logic                             valid_q, valid_d;
    logic [31:0]                      count_q, count_d;
    logic                             error_q, error_d;
    logic                             done_q, done_d;
    logic                             load;

    logic [NUM_OF_COLUMNS-1:0][31:0]  p_fields;
    logic [31:0]                      p_count;
    logic                             p_eof;
    logic [31:0]                      p_next;

    file_line_parser #(
        .NUM_OF_COLUMNS (NUM_OF_COLUMNS),
        .FILE_LEN       (FILE_LEN),
        .FILE_IMAGE     (FILE_NAME),
        .BASE           (Cfg.base),
        .CARRIAGE_RETURN(Cfg.carriage_return != 0)
    ) u_parser (
        .cursor_i(cursor_q),
        .fields_o(p_fields),
        .count_o (p_count),
        .eof_o   (p_eof),
        .next_o  (p_next)
    );

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        skip_d   = skip_q;
        data_d   = data_q;
        valid_d  = valid_q;
        count_d  = count_q;
        error_d  = error_q;
        done_d   = done_q;
        load     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable_in) begin
                    if (OpenFail) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = (Cfg.lines_to_skip == 0) ? S_FETCH : S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (p_eof) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cursor_d = p_next;
                    skip_d   = skip_q + 32'd1;
                    if (skip_q + 32'd1 >= 32'(Cfg.lines_to_skip)) state_d = S_FETCH;
                end
            end
            S_FETCH: load = enable_in;
            S_DRIVE: begin
                if (ready_in) begin
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    if ((Cfg.num_of_lines != 0) && (count_q + 32'd1 == 32'(Cfg.num_of_lines))) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (enable_in) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
        // Shared by FETCH and the handshake path so back-to-back lines need no extra cycle.
        if (load) begin
            if (p_eof) begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end else if (p_count < 32'(NUM_OF_COLUMNS)) begin
                valid_d = 1'b0;
                error_d = 1'b1;
                done_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                data_d   = p_fields;
                valid_d  = 1'b1;
                cursor_d = p_next;
                state_d  = S_DRIVE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cursor_q <= '0;
            skip_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            skip_q   <= skip_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign line_count = count_q;
    assign error_out  = error_q;
    assign all_done   = done_q;

endmodule

// File: tb/tb_single_file_stimulus.sv
// Bench for single_file_stimulus: vector table, hand sequences and a randomized run.
module tb_single_file_stimulus;

    localparam logic [8*20-1:0] ImgA = "1 2\n3 4\n\n5 6 7\n-8 9\n";
    localparam logic [8*21-1:0] ImgB = "hdr\015\nzz\015\nA 1F\015\nff 0\015\n";
    localparam logic [8*60-1:0] ImgC =
        "10 20\n11 21\n12 22\n13 23\n14 24\n15 25\n16 26\n17 27\n18 28\n19 29\n";
    localparam logic [8*14-1:0] ImgD = "1 2\n3 4\n5\n7 8\n";
    localparam logic [8*4-1:0]  ImgE = '0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic en_a = 0, rdy_a = 0, v_a, e_a, dn_a;
    logic en_b = 0, rdy_b = 0, v_b, e_b, dn_b;
    logic en_c = 0, rdy_c = 0, v_c, e_c, dn_c;
    logic en_d = 0, rdy_d = 0, v_d, e_d, dn_d;
    logic en_e = 0, rdy_e = 0, v_e, e_e, dn_e;
    logic en_r = 0, rdy_r = 0, v_r, e_r, dn_r;
    logic [1:0][31:0] d_a, d_b, d_c, d_d, d_e, d_r;
    logic [31:0] c_a, c_b, c_c, c_d, c_e, c_r;

    single_file_stimulus #(.NUM_OF_COLUMNS(2), .FILE_LEN(20), .FILE_NAME(ImgA), .NUM_OF_LINES(0),
        .BASE(10), .LINES_TO_SKIP(0), .VERBOSE(0), .CARRIAGE_RETURN(0)) u_a (
        .clk(clk), .reset_n(reset_n), .enable_in(en_a), .ready_in(rdy_a), .data_out(d_a),
        .valid_out(v_a), .line_count(c_a), .error_out(e_a), .all_done(dn_a));
    single_file_stimulus #(.NUM_OF_COLUMNS(2), .FILE_LEN(21), .FILE_NAME(ImgB), .NUM_OF_LINES(0),
        .BASE(16), .LINES_TO_SKIP(2), .VERBOSE(0), .CARRIAGE_RETURN(1)) u_b (
        .clk(clk), .reset_n(reset_n), .enable_in(en_b), .ready_in(rdy_b), .data_out(d_b),
        .valid_out(v_b), .line_count(c_b), .error_out(e_b), .all_done(dn_b));
    single_file_stimulus #(.NUM_OF_COLUMNS(2), .FILE_LEN(60), .FILE_NAME(ImgC), .NUM_OF_LINES(3),
        .BASE(10), .LINES_TO_SKIP(0), .VERBOSE(0), .CARRIAGE_RETURN(0)) u_c (
        .clk(clk), .reset_n(reset_n), .enable_in(en_c), .ready_in(rdy_c), .data_out(d_c),
        .valid_out(v_c), .line_count(c_c), .error_out(e_c), .all_done(dn_c));
    single_file_stimulus #(.NUM_OF_COLUMNS(2), .FILE_LEN(14), .FILE_NAME(ImgD), .NUM_OF_LINES(0),
        .BASE(10), .LINES_TO_SKIP(0), .VERBOSE(0), .CARRIAGE_RETURN(0)) u_d (
        .clk(clk), .reset_n(reset_n), .enable_in(en_d), .ready_in(rdy_d), .data_out(d_d),
        .valid_out(v_d), .line_count(c_d), .error_out(e_d), .all_done(dn_d));
    single_file_stimulus #(.NUM_OF_COLUMNS(2), .FILE_LEN(4), .FILE_NAME(ImgE), .NUM_OF_LINES(0),
        .BASE(10), .LINES_TO_SKIP(0), .VERBOSE(0), .CARRIAGE_RETURN(0)) u_e (
        .clk(clk), .reset_n(reset_n), .enable_in(en_e), .ready_in(rdy_e), .data_out(d_e),
        .valid_out(v_e), .line_count(c_e), .error_out(e_e), .all_done(dn_e));
    single_file_stimulus #(.NUM_OF_COLUMNS(2), .FILE_LEN(60), .FILE_NAME(ImgC), .NUM_OF_LINES(0),
        .BASE(10), .LINES_TO_SKIP(0), .VERBOSE(0), .CARRIAGE_RETURN(0)) u_r (
        .clk(clk), .reset_n(reset_n), .enable_in(en_r), .ready_in(rdy_r), .data_out(d_r),
        .valid_out(v_r), .line_count(c_r), .error_out(e_r), .all_done(dn_r));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit en;
        bit rdy;
        bit v;
        int d0;
        int d1;
        int cnt;
        bit done;
    } vec_t;

    vec_t tab[8];
    int   rdy_seq[6] = '{1, 0, 0, 1, 1, 1};
    int   cnt_seq[6] = '{1, 1, 1, 2, 3, 3};
    int   v_seq[6]   = '{1, 1, 1, 1, 0, 0};
    int   d_seq[6]   = '{11, 11, 11, 12, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  ec;
        bit  pv, pr;

        tab[0] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0};
        tab[1] = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0};
        tab[2] = '{1'b1, 1'b1, 1'b1, 1, 2, 0, 1'b0};
        tab[3] = '{1'b1, 1'b1, 1'b1, 3, 4, 1, 1'b0};
        tab[4] = '{1'b1, 1'b1, 1'b1, 5, 6, 2, 1'b0};
        tab[5] = '{1'b1, 1'b1, 1'b1, -8, 9, 3, 1'b0};
        tab[6] = '{1'b1, 1'b1, 1'b0, 0, 0, 4, 1'b1};
        tab[7] = '{1'b1, 1'b1, 1'b0, 0, 0, 4, 1'b1};

        // Reset state
        tick();
        chk("rst_valid", v_a, 0);
        chk("rst_count", c_a, 0);
        chk("rst_done", dn_a, 0);
        chk("rst_error", e_a, 0);
        chk("rst_data", d_a[0] | d_a[1], 0);
        tick();
        reset_n = 1'b1;

        // A: 4 data lines incl. blank line, extra field and negative value
        for (int i = 0; i < 8; i++) begin
            en_a  = tab[i].en;
            rdy_a = tab[i].rdy;
            tick();
            chk($sformatf("a_valid[%0d]", i), v_a, tab[i].v);
            chk($sformatf("a_count[%0d]", i), c_a, tab[i].cnt);
            chk($sformatf("a_done[%0d]", i), dn_a, tab[i].done);
            chk($sformatf("a_error[%0d]", i), e_a, 0);
            if (tab[i].v) begin
                chk($sformatf("a_d0[%0d]", i), d_a[0], tab[i].d0);
                chk($sformatf("a_d1[%0d]", i), d_a[1], tab[i].d1);
            end
        end

        // B: hex, two header lines, CR stripped
        en_b = 1'b1;
        n = 0;
        while (!v_b && n < 20) begin
            tick();
            n++;
        end
        chk("b_latency", n, 4);
        chk("b_d0", d_b[0], 10);
        chk("b_d1", d_b[1], 31);
        rdy_b = 1'b1;
        tick();
        chk("b_next_d0", d_b[0], 255);
        chk("b_next_d1", d_b[1], 0);
        tick();
        chk("b_done", dn_b, 1);
        chk("b_count", c_b, 2);
        chk("b_error", e_b, 0);

        // C: ready pattern with a 3-line limit on a 10-line file
        en_c = 1'b1;
        n = 0;
        while (!v_c && n < 20) begin
            tick();
            n++;
        end
        chk("c_latency", n, 2);
        chk("c_first_d0", d_c[0], 10);
        chk("c_first_count", c_c, 0);
        for (int i = 0; i < 6; i++) begin
            rdy_c = rdy_seq[i][0];
            tick();
            chk($sformatf("c_count[%0d]", i), c_c, cnt_seq[i]);
            chk($sformatf("c_valid[%0d]", i), v_c, v_seq[i]);
            if (v_seq[i] != 0) begin
                chk($sformatf("c_d0[%0d]", i), d_c[0], d_seq[i]);
                chk($sformatf("c_d1[%0d]", i), d_c[1], d_seq[i] + 10);
            end
        end
        chk("c_done", dn_c, 1);

        // D: short third line
        en_d  = 1'b1;
        rdy_d = 1'b1;
        n = 0;
        while (!dn_d && n < 20) begin
            tick();
            n++;
        end
        chk("d_done", dn_d, 1);
        chk("d_error", e_d, 1);
        chk("d_count", c_d, 2);
        chk("d_valid", v_d, 0);

        // E: missing file
        en_e = 1'b1;
        tick();
        chk("e_error", e_e, 1);
        chk("e_done", dn_e, 1);
        chk("e_valid", v_e, 0);

        // R: random enable/ready against the line-order model
        ec = 0;
        for (int i = 0; i < 400 && !dn_r; i++) begin
            en_r  = ($urandom_range(3) != 0);
            rdy_r = 1'($urandom_range(1));
            pv = v_r;
            pr = rdy_r;
            tick();
            if (pv && pr) ec++;
            chk("r_count", c_r, ec);
            if (pv && !pr) chk("r_hold", v_r, 1);
            if (v_r) begin
                chk("r_d0", d_r[0], 10 + ec);
                chk("r_d1", d_r[1], 20 + ec);
            end
            if (dn_r) chk("r_done_valid", v_r, 0);
        end
        chk("r_finished", dn_r, 1);
        chk("r_final_count", c_r, 10);
        chk("r_error", e_r, 0);

        // Reset mid-transfer clears asynchronously and rewinds
        reset_n = 1'b0;
        #1;
        chk("ar_valid", v_a, 0);
        chk("ar_count", c_a, 0);
        chk("ar_done", dn_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        en_a  = 1'b1;
        rdy_a = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("ar_pre_count", c_a, 2);
        chk("ar_pre_d0", d_a[0], 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar2_valid", v_a, 0);
        chk("ar2_count", c_a, 0);
        chk("ar2_data", d_a[0] | d_a[1], 0);
        chk("ar2_error", e_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!v_a && n < 20) begin
            tick();
            n++;
        end
        chk("ar_replay_latency", n, 2);
        chk("ar_replay_d0", d_a[0], 1);
        chk("ar_replay_d1", d_a[1], 2);
        chk("ar_replay_count", c_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
